// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared branch-predictor types and constants for the MIPS pipeline.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    // Applied to pc[30:0] only, so the kernel bit never sees a carry.
    localparam logic [30:0] FALL_THROUGH_INC = 31'd4;

    // Tag storage is sized for the widest usable tag; narrower builds
    // zero-extend and the constant upper bits fold away in synthesis.
    localparam int MAX_TAG_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] tag;
        logic                 kernel;
        logic [1:0]           ctr;
        logic [31:0]          target;
    } bp_entry_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/sat_counter2.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter2
// Brief    : Next-state function of a 2-bit saturating direction counter.
// Revision : 1.0
// ============================================================================
module sat_counter2
    import cpu_pkg::*;
(
    input  logic [1:0] i_ctr,
    input  logic       i_up,
    output logic [1:0] o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_up) begin
            if (i_ctr != STRONG_T) begin
                o_ctr = i_ctr + 2'd1;
            end
        end else begin
            if (i_ctr != STRONG_NT) begin
                o_ctr = i_ctr - 2'd1;
            end
        end
    end

endmodule : sat_counter2
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Brief    : Direct-mapped 2-bit counter + BTB predictor, IF lookup / EX update.
// Revision : 1.0
// ============================================================================
module branch_predictor
    import cpu_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int INDEX_W = $clog2(ENTRIES),
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      lookup_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    output logic             pred_hit,
    input  logic             update_valid,
    input  logic [31:0]      update_pc,
    input  logic             update_taken,
    input  logic [31:0]      update_target,
    input  logic             update_pred_taken,
    input  logic [31:0]      update_pred_target,
    input  logic             invalidate,
    output logic             mispredict,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispredicts
);

    bp_entry_t r_table [ENTRIES];

    logic [INDEX_W-1:0]   w_lookup_idx;
    logic [MAX_TAG_W-1:0] w_lookup_tag;
    bp_entry_t            w_lookup_entry;

    logic [INDEX_W-1:0]   w_upd_idx;
    logic [MAX_TAG_W-1:0] w_upd_tag;
    bp_entry_t            w_upd_entry;
    logic                 w_upd_hit;
    logic [1:0]           w_upd_next_ctr;

    logic [CNT_W-1:0]     r_perf_branches;
    logic [CNT_W-1:0]     r_perf_mispredicts;

    // Which PC bits feed index/tag depends on the build; fold the rest here.
    logic w_unused_pc_bits;
    assign w_unused_pc_bits = ^{lookup_pc, update_pc};

    // ---------------- IF lookup ----------------
    assign w_lookup_idx   = lookup_pc[INDEX_W+1:2];
    assign w_lookup_tag   = MAX_TAG_W'(lookup_pc[INDEX_W+2 +: TAG_W]);
    assign w_lookup_entry = r_table[w_lookup_idx];

    assign pred_hit    = w_lookup_entry.valid
                       && (w_lookup_entry.tag == w_lookup_tag)
                       && (w_lookup_entry.kernel == lookup_pc[31]);
    assign pred_taken  = pred_hit && w_lookup_entry.ctr[1];
    assign pred_target = pred_taken ? w_lookup_entry.target
                                    : {lookup_pc[31], lookup_pc[30:0] + FALL_THROUGH_INC};

    // ---------------- EX update ----------------
    assign w_upd_idx   = update_pc[INDEX_W+1:2];
    assign w_upd_tag   = MAX_TAG_W'(update_pc[INDEX_W+2 +: TAG_W]);
    assign w_upd_entry = r_table[w_upd_idx];
    assign w_upd_hit   = w_upd_entry.valid
                       && (w_upd_entry.tag == w_upd_tag)
                       && (w_upd_entry.kernel == update_pc[31]);

    sat_counter2 u_upd_ctr (
        .i_ctr (w_upd_entry.ctr),
        .i_up  (update_taken),
        .o_ctr (w_upd_next_ctr)
    );

    assign mispredict = update_valid
                      && ((update_taken != update_pred_taken)
                          || (update_taken && update_pred_taken
                              && (update_target != update_pred_target)));

    // Invalidate wins over a same-cycle update; the update is simply dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= '0;
            end
        end else if (invalidate) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i].valid <= 1'b0;
            end
        end else if (update_valid) begin
            if (w_upd_hit) begin
                r_table[w_upd_idx].ctr <= w_upd_next_ctr;
                if (update_taken) begin
                    r_table[w_upd_idx].target <= update_target;
                end
            end else if (update_taken) begin
                r_table[w_upd_idx] <= '{valid:  1'b1,
                                        tag:    w_upd_tag,
                                        kernel: update_pc[31],
                                        ctr:    WEAK_T,
                                        target: update_target};
            end
        end
    end

    // ---------------- performance counters ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_branches    <= '0;
            r_perf_mispredicts <= '0;
        end else if (update_valid) begin
            if (r_perf_branches != '1) begin
                r_perf_branches <= r_perf_branches + CNT_W'(1);
            end
            if (mispredict && (r_perf_mispredicts != '1)) begin
                r_perf_mispredicts <= r_perf_mispredicts + CNT_W'(1);
            end
        end
    end

    assign perf_branches    = r_perf_branches;
    assign perf_mispredicts = r_perf_mispredicts;

endmodule : branch_predictor
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Brief    : Directed + random bench for branch_predictor with an array model.
// Revision : 1.0
// ============================================================================
module tb_branch_predictor;

    localparam int ENT  = 16;
    localparam int IW   = 4;
    localparam int TW   = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   lookup_pc = 32'h0;
    logic          pred_taken;
    logic [31:0]   pred_target;
    logic          pred_hit;
    logic          update_valid = 1'b0;
    logic [31:0]   update_pc = 32'h0;
    logic          update_taken = 1'b0;
    logic [31:0]   update_target = 32'h0;
    logic          update_pred_taken = 1'b0;
    logic [31:0]   update_pred_target = 32'h0;
    logic          invalidate = 1'b0;
    logic          mispredict;
    logic [CW-1:0] perf_branches;
    logic [CW-1:0] perf_mispredicts;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one record per table slot, counters as plain integers.
    bit          m_valid  [ENT];
    int          m_tag    [ENT];
    bit          m_kernel [ENT];
    int          m_ctr    [ENT];
    logic [31:0] m_target [ENT];
    int          m_br;
    int          m_mp;

    branch_predictor #(
        .ENTRIES (ENT),
        .TAG_W   (TW),
        .CNT_W   (CW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .lookup_pc          (lookup_pc),
        .pred_taken         (pred_taken),
        .pred_target        (pred_target),
        .pred_hit           (pred_hit),
        .update_valid       (update_valid),
        .update_pc          (update_pc),
        .update_taken       (update_taken),
        .update_target      (update_target),
        .update_pred_taken  (update_pred_taken),
        .update_pred_target (update_pred_target),
        .invalidate         (invalidate),
        .mispredict         (mispredict),
        .perf_branches      (perf_branches),
        .perf_mispredicts   (perf_mispredicts)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENT);
    endfunction

    function automatic int m_tagof(input logic [31:0] pc);
        return int'((pc >> (2 + IW)) % (1 << TW));
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int i;
        i = m_idx(pc);
        return m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_kernel[i] == pc[31]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_kernel[i] = 0; m_ctr[i] = 0; m_target[i] = 32'h0;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic model_update(input bit v, input logic [31:0] pc, input bit tk,
                                input logic [31:0] tgt, input bit mp, input bit inv);
        int i;
        if (!v && !inv) return;
        if (v) begin
            if (m_br < CMAX) m_br++;
            if (mp && m_mp < CMAX) m_mp++;
        end
        if (inv) begin
            for (int k = 0; k < ENT; k++) m_valid[k] = 0;
            return;
        end
        i = m_idx(pc);
        if (m_hit(pc)) begin
            if (tk) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_target[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (tk) begin
            m_valid[i] = 1; m_tag[i] = m_tagof(pc); m_kernel[i] = pc[31];
            m_ctr[i] = 2; m_target[i] = tgt;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_lookup(input string tag);
        bit          h, t;
        logic [31:0] tg;
        h  = m_hit(lookup_pc);
        t  = h && (m_ctr[m_idx(lookup_pc)] >= 2);
        tg = t ? m_target[m_idx(lookup_pc)]
               : {lookup_pc[31], 31'(lookup_pc[30:0] + 31'd4)};
        chk({tag, ".hit"},    {31'd0, pred_hit},   {31'd0, h});
        chk({tag, ".taken"},  {31'd0, pred_taken}, {31'd0, t});
        chk({tag, ".target"}, pred_target, tg);
    endtask

    task automatic check_perf(input string tag);
        chk({tag, ".perf_br"}, 32'(perf_branches),    32'(m_br));
        chk({tag, ".perf_mp"}, 32'(perf_mispredicts), 32'(m_mp));
    endtask

    // One EX update with a same-cycle IF lookup, checked before and after the edge.
    task automatic step(input string tag, input bit v, input logic [31:0] pc, input bit tk,
                        input logic [31:0] tgt, input bit ptk, input logic [31:0] ptgt,
                        input bit inv, input logic [31:0] lpc);
        bit exp_mp;
        @(negedge clk);
        update_valid = v; update_pc = pc; update_taken = tk; update_target = tgt;
        update_pred_taken = ptk; update_pred_target = ptgt; invalidate = inv;
        lookup_pc = lpc;
        exp_mp = v && ((tk != ptk) || (tk && ptk && (tgt != ptgt)));
        #1;
        chk({tag, ".mispredict"}, {31'd0, mispredict}, {31'd0, exp_mp});
        check_lookup({tag, ".pre"});
        @(posedge clk);
        model_update(v, pc, tk, tgt, exp_mp, inv);
        #1;
        update_valid = 1'b0;
        invalidate   = 1'b0;
        #1;
        check_lookup({tag, ".post"});
        check_perf(tag);
    endtask

    // Asynchronous reset raised and released between clock edges.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check_lookup(tag);
        check_perf(tag);
        #1;
        reset = 1'b0;
    endtask

    logic [31:0] r_pc, r_tgt, r_ptgt, r_lpc;
    bit          r_v, r_tk, r_ptk, r_inv;

    initial begin
        model_reset();
        lookup_pc = 32'h8000_0010;
        #12;
        chk("rst.hit",    {31'd0, pred_hit},   32'd0);
        chk("rst.taken",  {31'd0, pred_taken}, 32'd0);
        chk("rst.target", pred_target, 32'h8000_0014);
        check_perf("rst");
        @(negedge clk);
        reset = 1'b0;

        chk("wrap.target", {1'b0, 31'h7FFF_FFFC} + 32'h0, 32'h7FFF_FFFC);
        lookup_pc = 32'h7FFF_FFFC;
        #1;
        chk("wrap.ft", pred_target, 32'h0000_0000);

        step("alloc", 1, 32'h0040_0020, 1, 32'h0040_0100, 0, 32'h0, 0, 32'h0040_0020);
        chk("alloc.lit_target", pred_target, 32'h0040_0100);
        chk("alloc.lit_br", 32'(perf_branches), 32'd1);
        chk("alloc.lit_mp", 32'(perf_mispredicts), 32'd1);

        step("nt1", 1, 32'h0040_0020, 0, 32'h0, 1, 32'h0040_0100, 0, 32'h0040_0020);
        chk("nt1.lit_taken", {31'd0, pred_taken}, 32'd0);
        step("nt2", 1, 32'h0040_0020, 0, 32'h0, 0, 32'h0, 0, 32'h0040_0020);
        for (int k = 0; k < 4; k++)
            step("tk", 1, 32'h0040_0020, 1, 32'h0040_0200, 0, 32'h0, 0, 32'h0040_0020);
        step("sat_up", 1, 32'h0040_0020, 0, 32'h0, 1, 32'h0040_0200, 0, 32'h0040_0020);
        chk("sat_up.lit_taken", {31'd0, pred_taken}, 32'd1);

        step("aliasA", 1, 32'h0000_0040, 1, 32'h0000_1000, 0, 32'h0, 0, 32'h8000_4040);
        chk("aliasB.lit_hit", {31'd0, pred_hit}, 32'd0);
        lookup_pc = 32'h0000_4040;
        #1;
        check_lookup("aliasB_user");
        step("replace", 1, 32'h0000_0080, 1, 32'h0000_2000, 0, 32'h0, 0, 32'h0000_0040);
        chk("replace.lit_hit", {31'd0, pred_hit}, 32'd0);

        step("inval", 1, 32'h0000_1100, 1, 32'h0000_3000, 0, 32'h0, 1, 32'h0000_0080);
        for (int k = 0; k < 4; k++) begin
            lookup_pc = (k == 0) ? 32'h0000_1100 : (k == 1) ? 32'h0040_0020
                      : (k == 2) ? 32'h0000_0080 : 32'h0000_4040;
            #1;
            chk("inval.nohit", {31'd0, pred_hit}, 32'd0);
        end

        async_reset("mid_reset");
        for (int k = 0; k < 16; k++)
            step("mp_fill", 1, 32'h0000_0200, 1, 32'h0000_0300 + 32'(k * 4), 1,
                 32'h0000_0AA0, 0, 32'h0000_0200);
        chk("mp_sat.lit", 32'(perf_mispredicts), 32'hF);
        step("mp_sat", 1, 32'h0000_0200, 0, 32'h0, 1, 32'h0000_0300, 0, 32'h0000_0200);
        chk("mp_sat.lit2", 32'(perf_mispredicts), 32'hF);
        chk("br_sat.lit", 32'(perf_branches), 32'hF);
        async_reset("mid_reset2");

        for (int n = 0; n < 400; n++) begin
            if (n % 60 == 59) async_reset("rnd_reset");
            r_pc   = ($urandom & 32'h0000_01FC) | (($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'h0);
            r_tgt  = $urandom & 32'hFFFF_FFFC;
            r_v    = ($urandom_range(0, 3) != 0);
            r_tk   = $urandom_range(0, 1);
            r_ptk  = $urandom_range(0, 1);
            r_ptgt = ($urandom_range(0, 1) != 0) ? r_tgt : ($urandom & 32'hFFFF_FFFC);
            r_inv  = ($urandom_range(0, 19) == 0);
            r_lpc  = ($urandom_range(0, 1) != 0) ? r_pc
                   : (($urandom & 32'h0000_01FC) | (($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'h0));
            step("rnd", r_v, r_pc, r_tk, r_tgt, r_ptk, r_ptgt, r_inv, r_lpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_branch_predictor
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage MIPS pipeline. It replaces the static predict-not-taken scheme, where every taken branch resolved in EX costs a flush.
- IF stage: combinational lookup on the fetch PC returns a predicted direction and target in the same cycle.
- EX stage: the resolved branch outcome updates a direct-mapped table of 2-bit saturating counters and targets (a BTB).
- Also keeps branch and mispredict performance counters for the bus/debug path.

Parameters:
- ENTRIES, 64, number of table entries; power of two, minimum 4.
- INDEX_W, $clog2(ENTRIES), index width; derived, not overridden.
- TAG_W, 8, tag bits stored per entry, taken from the PC above the index.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- lookup_pc  in  32  current IF PC
- pred_taken  out  1  predicted taken for lookup_pc
- pred_target  out  32  predicted next PC
- pred_hit  out  1  valid tag match for lookup_pc
- update_valid  in  1  a branch resolved in EX this cycle
- update_pc  in  32  PC of the resolved branch
- update_taken  in  1  actual outcome
- update_target  in  32  actual taken target
- update_pred_taken  in  1  prediction carried down the pipeline with this branch
- update_pred_target  in  32  predicted target carried down the pipeline
- invalidate  in  1  clear all entries (context switch / exception entry)
- mispredict  out  1  combinational; current update disagrees with its prediction
- perf_branches  out  CNT_W  resolved-branch count
- perf_mispredicts  out  CNT_W  mispredict count

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk. On reset, every valid bit, counter, tag and target clears to 0, and perf_branches = perf_mispredicts = 0.
  - Lookup outputs are combinational, so after reset they read as a miss: pred_hit=0, pred_taken=0, pred_target = fall-through.
- Address split:
  - idx = pc[INDEX_W+1:2]
  - tag = pc[INDEX_W+2 +: TAG_W]
  - Each entry also stores the kernel bit pc[31]. A hit requires valid, tag match and kernel match.
- Entry contents: valid, tag[TAG_W], kernel, ctr[1:0], target[31:0].
- Lookup (zero latency, combinational):
  - pred_taken = hit & ctr[1].
  - pred_target = stored target when pred_taken; otherwise {lookup_pc[31], lookup_pc[30:0]+4}. Carry out of bit 30 wraps and never touches bit 31.
- Update (registered, at posedge clk when update_valid=1 and invalidate=0):
  - Hit, taken: ctr saturates up (max 2'b11); target <= update_target.
  - Hit, not taken: ctr saturates down (min 2'b00); target unchanged; entry stays valid.
  - Miss, taken: allocate and overwrite any aliasing entry. valid=1, tag/kernel from update_pc, ctr=2'b10 (weakly taken), target=update_target.
  - Miss, not taken: no table change.
- mispredict = update_valid & ((update_taken != update_pred_taken) | (update_taken & update_pred_taken & (update_target != update_pred_target))).
- Perf counters:
  - On each update_valid cycle, perf_branches increments; perf_mispredicts also increments when mispredict=1.
  - Both saturate at all-ones, with no wrap.
  - Both still count when invalidate is asserted the same cycle.
- invalidate:
  - At the next edge, all valid bits clear.
  - It takes priority over a same-cycle table update, which is dropped.
  - Counters and targets need not be cleared.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents; there is no bypass. The new state is visible the following cycle.
- update_pc and update_target bit 31 are stored as given; the predictor does no kernel-mode checking beyond the tag match.

Decomposition:
- Shared package cpu_pkg holds:
  - counter encodings: STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11
  - the fall-through increment constant
  - the entry struct typedef (valid, tag, kernel, ctr, target).
- One natural sub-module, sat_counter2: 2-bit saturating counter next-state function, instantiated per update path.
- The table itself stays in branch_predictor as a flop array; async reset is incompatible with RAM inference.

Test Plan:
- After reset, lookup_pc=0x80000010 -> pred_hit=0, pred_taken=0, pred_target=0x80000014; both perf counters read 0.
- Update pc=0x00400020, taken, target=0x00400100, pred_taken=0 -> mispredict=1; next cycle lookup 0x00400020 gives hit=1, taken=1, target=0x00400100; perf_branches=1, perf_mispredicts=1.
- Same pc: two not-taken updates -> ctr 10→01→00, pred_taken=0; three taken updates -> 00→01→10→11; a fourth taken update stays at 11.
- Alias: pc A=0x00000040 allocated taken. Then B = A + (ENTRIES*4<<TAG_W), a different upper PC with the same tag bits, fetched in kernel mode (bit31=1) -> pred_hit=0. Taken update at A+ENTRIES*4 replaces entry; lookup A -> hit=0.
- invalidate together with a taken update on a new pc -> the next cycle has no hits anywhere, the table is unchanged by that update, and perf_branches still increments.
- Force perf_mispredicts to all-ones (CNT_W=4 build), then apply another mispredicting update -> stays 4'hF; same-cycle lookup at the updated index returns the old value; async reset mid-run clears all state before the next edge.
